// File: rtl/sb_arbiter_if.sv
// Bus bundle for sb_arbiter: both master ports plus the shared peripheral slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's.
interface sb_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              m0_req_i;
   logic              m0_we_i;
   logic [ADDR_W-1:0] m0_addr_i;
   logic [DATA_W-1:0] m0_wd_i;
   logic              m0_lock_i;
   logic              m0_ack_o;
   logic [DATA_W-1:0] m0_rd_o;

   logic              m1_req_i;
   logic              m1_we_i;
   logic [ADDR_W-1:0] m1_addr_i;
   logic [DATA_W-1:0] m1_wd_i;
   logic              m1_lock_i;
   logic              m1_ack_o;
   logic [DATA_W-1:0] m1_rd_o;

   logic              sb_req_o;
   logic              sb_we_o;
   logic [ADDR_W-1:0] sb_addr_o;
   logic [DATA_W-1:0] sb_wd_o;
   logic [DATA_W-1:0] sb_rd_i;

   modport slave (
      input  m0_req_i, m0_we_i, m0_addr_i, m0_wd_i, m0_lock_i,
      input  m1_req_i, m1_we_i, m1_addr_i, m1_wd_i, m1_lock_i,
      input  sb_rd_i,
      output m0_ack_o, m0_rd_o, m1_ack_o, m1_rd_o,
      output sb_req_o, sb_we_o, sb_addr_o, sb_wd_o
   );

   modport master (
      output m0_req_i, m0_we_i, m0_addr_i, m0_wd_i, m0_lock_i,
      output m1_req_i, m1_we_i, m1_addr_i, m1_wd_i, m1_lock_i,
      output sb_rd_i,
      input  m0_ack_o, m0_rd_o, m1_ack_o, m1_rd_o,
      input  sb_req_o, sb_we_o, sb_addr_o, sb_wd_o
   );
endinterface

// File: rtl/sb_arbiter.sv
// Two-master round-robin arbiter onto one peripheral slave port: IDLE latches a winner, ACCESS
// issues one bus cycle and acks. Define SB_ARB_LOCK_EN to honour the masters' lock hints.
module sb_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_LOCK = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   sb_arbiter_if.slave bus
);
   localparam logic IDLE   = 1'b0;
   localparam logic ACCESS = 1'b1;
   localparam logic M0     = 1'b0;
   localparam logic M1     = 1'b1;

   logic              state;
   logic              last_grant;
   logic              win;
   logic [1:0]        req;
   logic [1:0]        ack;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wd_q;
   logic [DATA_W-1:0] rd0_q;
   logic [DATA_W-1:0] rd1_q;

   assign req = {bus.m1_req_i, bus.m0_req_i};

`ifdef SB_ARB_LOCK_EN
   localparam int unsigned LOCK_W = $clog2(MAX_LOCK + 1);

   logic [LOCK_W-1:0] lock_cnt;
   logic              last_lock;
   logic [1:0]        lock;

   assign lock = {bus.m1_lock_i, bus.m0_lock_i};
`else
   logic unused_lock;
   assign unused_lock = bus.m0_lock_i ^ bus.m1_lock_i ^ (MAX_LOCK == 0);
`endif

   // On a tie the master that was not served last wins; a lone requester always wins.
   always_comb begin
      if (req[0] && req[1]) win = ~last_grant;
      else                  win = req[1];
`ifdef SB_ARB_LOCK_EN
      if (last_lock && req[last_grant] &&
          ((lock_cnt < LOCK_W'(MAX_LOCK)) || !req[~last_grant]))
         win = last_grant;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         last_grant <= M1;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wd_q       <= '0;
         ack        <= '0;
         rd0_q      <= '0;
         rd1_q      <= '0;
      end else begin
         ack <= '0;
         if (state == IDLE) begin
            if (|req) begin
               last_grant <= win;
               we_q       <= (win == M1) ? bus.m1_we_i   : bus.m0_we_i;
               addr_q     <= (win == M1) ? bus.m1_addr_i : bus.m0_addr_i;
               wd_q       <= (win == M1) ? bus.m1_wd_i   : bus.m0_wd_i;
               state      <= ACCESS;
            end
         end else begin
            ack[last_grant] <= 1'b1;
            if (!we_q) begin
               if (last_grant == M1) rd1_q <= bus.sb_rd_i;
               else                  rd0_q <= bus.sb_rd_i;
            end
            state <= IDLE;
         end
      end
   end

`ifdef SB_ARB_LOCK_EN
   // A locked grant after a change of owner (or after an unlocked grant) starts a new run at 1.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_cnt  <= '0;
         last_lock <= 1'b0;
      end else if (state == IDLE && |req) begin
         last_lock <= lock[win];
         if (!lock[win])
            lock_cnt <= '0;
         else if (win != last_grant || !last_lock)
            lock_cnt <= LOCK_W'(1);
         else if (lock_cnt < LOCK_W'(MAX_LOCK))
            lock_cnt <= lock_cnt + 1'b1;
      end
   end
`endif

   assign bus.sb_req_o  = (state == ACCESS);
   assign bus.sb_we_o   = we_q;
   assign bus.sb_addr_o = addr_q;
   assign bus.sb_wd_o   = wd_q;
   assign bus.m0_ack_o  = ack[0];
   assign bus.m1_ack_o  = ack[1];
   assign bus.m0_rd_o   = rd0_q;
   assign bus.m1_rd_o   = rd1_q;
endmodule
